// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode hazard controller.
package hazard_pkg;

   localparam int REG_IDX_W = 5;
   localparam int CNT_W_DEF = 2;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register pending-write counters with busy mask and sticky underflow flag.
module hz_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        inc_en_i,
   input  reg_idx_t                    inc_idx_i,
   input  logic                        dec_en_i,
   input  reg_idx_t                    dec_idx_i,
   output logic [NREGS-1:0][CNT_W-1:0] cnt_o,
   output logic [NREGS-1:0]            busy_mask_o,
   output logic                        err_underflow_o
);

   logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                        err_q, err_d;
   logic [NREGS-1:0]            inc_vec, dec_vec;
   logic                        underflow;

   // x0 is never tracked: entry 0 stays at zero and never raises underflow.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int i = 1; i < NREGS; i++) begin
         inc_vec[i] = inc_en_i && (inc_idx_i == reg_idx_t'(i));
         dec_vec[i] = dec_en_i && (dec_idx_i == reg_idx_t'(i)) && (cnt_q[i] != '0);
      end
   end

   assign underflow = dec_en_i && (dec_idx_i != '0) && (cnt_q[dec_idx_i] == '0);

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q | underflow;
      for (int i = 1; i < NREGS; i++) begin
         case ({inc_vec[i], dec_vec[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      busy_mask_o = '0;
      for (int i = 0; i < NREGS; i++) begin
         busy_mask_o[i] = (cnt_q[i] != '0);
      end
   end

   assign cnt_o           = cnt_q;
   assign err_underflow_o = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode hazard controller: RAW/saturation stall, post-redirect squash, write scoreboard.
// Optional HAZARD_WB_BYPASS_EN: a same-cycle writeback of the last pending write releases the stall.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NREGS        = 32,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dec_valid,
   input  reg_idx_t         dec_rs1,
   input  logic             dec_rs1_used,
   input  reg_idx_t         dec_rs2,
   input  logic             dec_rs2_used,
   input  reg_idx_t         dec_rd,
   input  logic             dec_rd_write,
   input  logic             wb_valid,
   input  reg_idx_t         wb_rd,
   input  logic             flush_in,
   output logic             dec_hold,
   output logic             dec_kill,
   output logic             issue,
   output logic [NREGS-1:0] busy_mask,
   output logic             err_underflow,
   output hz_state_e        dbg_state
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   hz_state_e                   state_q, state_d;
   logic [FC_W-1:0]             flush_cnt_q, flush_cnt_d;
   logic [NREGS-1:0][CNT_W-1:0] cnt;
   logic [NREGS-1:0]            sb_busy;
   logic                        sb_err;
   logic [CNT_W-1:0]            rs1_cnt, rs2_cnt, rd_cnt;
   logic                        rs1_byp, rs2_byp;
   logic                        rs1_stall, rs2_stall, rd_full, hazard;
   logic                        hold_c, kill_c, issue_c;

   assign rs1_cnt = cnt[dec_rs1];
   assign rs2_cnt = cnt[dec_rs2];
   assign rd_cnt  = cnt[dec_rd];

`ifdef HAZARD_WB_BYPASS_EN
   // Register file writes through, so the final outstanding write can be read this cycle.
   assign rs1_byp = wb_valid && (wb_rd == dec_rs1) && (rs1_cnt == CNT_W'(1));
   assign rs2_byp = wb_valid && (wb_rd == dec_rs2) && (rs2_cnt == CNT_W'(1));
`else
   assign rs1_byp = 1'b0;
   assign rs2_byp = 1'b0;
`endif

   assign rs1_stall = dec_rs1_used && (dec_rs1 != '0) && (rs1_cnt != '0) && !rs1_byp;
   assign rs2_stall = dec_rs2_used && (dec_rs2 != '0) && (rs2_cnt != '0) && !rs2_byp;
   // A saturated counter cannot accept another writer, so that writer waits.
   assign rd_full   = dec_rd_write && (dec_rd != '0) && (rd_cnt == CNT_MAX);
   assign hazard    = dec_valid && (rs1_stall || rs2_stall || rd_full);

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      hold_c      = 1'b0;
      kill_c      = 1'b0;
      issue_c     = 1'b0;
      case (state_q)
         RUN: begin
            hold_c  = hazard;
            issue_c = dec_valid && !hazard && !flush_in;
            kill_c  = flush_in;
         end
         FLUSH: begin
            kill_c = 1'b1;
            if (flush_cnt_q == '0) state_d = RUN;
            else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
         end
         default: state_d = RUN;
      endcase
      if (flush_in) begin
         state_d     = FLUSH;
         flush_cnt_d = FC_LOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   hz_scoreboard #(
      .NREGS (NREGS),
      .CNT_W (CNT_W)
   ) u_sb (
      .clk             (clk),
      .reset           (reset),
      .inc_en_i        (issue && dec_rd_write && (dec_rd != '0)),
      .inc_idx_i       (dec_rd),
      .dec_en_i        (wb_valid),
      .dec_idx_i       (wb_rd),
      .cnt_o           (cnt),
      .busy_mask_o     (sb_busy),
      .err_underflow_o (sb_err)
   );

   // Registered state may still be stale in the first reset cycle; outputs are forced quiet.
   assign dec_hold      = !reset && hold_c;
   assign dec_kill      = !reset && kill_c;
   assign issue         = !reset && issue_c;
   assign busy_mask     = reset ? '0 : sb_busy;
   assign err_underflow = !reset && sb_err;
   assign dbg_state     = state_q;

endmodule
